// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared CPU memory-size constants and instruction-loader state encoding
package inst_loader_pkg;
  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_WORD_W = 16;
  localparam int IMEM_DEPTH = 1 << IMEM_ADDR_W;
  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_WORD_W = 8;
  localparam int DMEM_DEPTH = 1 << DMEM_ADDR_W;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;
endpackage

// File: rtl/inst_loader.sv
// inst_loader: byte-stream loader writing count-prefixed instruction words into instruction memory
// Define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte and report mismatches on error.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int WORD_W = IMEM_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error
);
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_LAST = S_CSUM;
`else
  localparam logic [2:0] S_LAST = S_FIN;
`endif
  logic [2:0] state;
  logic [8:0] cnt;
  logic xfer;
  assign in_ready = state == S_COUNT || state == S_HI || state == S_LO || state == S_CSUM;
  assign xfer = in_valid & in_ready;
  assign busy = state != S_IDLE;
  // a count byte of 0 sets bit 8, giving 256 words
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done <= 1'b0;
    end else begin
      wr_en <= xfer && state == S_LO;
      if (wr_en) wr_addr <= wr_addr + ADDR_W'(1);
      case (state)
        S_IDLE:
          if (start) begin
            state <= S_COUNT;
            done <= 1'b0;
            wr_addr <= '0;
          end
        S_COUNT:
          if (xfer) begin
            cnt <= {in_data == 8'd0, in_data};
            state <= S_HI;
          end
        S_HI:
          if (xfer) begin
            wr_data[WORD_W-1 -: 8] <= in_data;
            state <= S_LO;
          end
        S_LO:
          if (xfer) begin
            wr_data[7:0] <= in_data;
            cnt <= cnt - 9'd1;
            state <= cnt == 9'd1 ? S_LAST : S_HI;
          end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: if (xfer) state <= S_FIN;
`endif
        S_FIN: begin
          state <= S_IDLE;
          done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      csum <= '0;
      error <= 1'b0;
    end else if (state == S_IDLE && start) begin
      csum <= '0;
      error <= 1'b0;
    end else if (xfer) begin
      if (state == S_CSUM) error <= in_data != csum;
      else csum <= csum ^ in_data;
    end
`else
  assign error = 1'b0;
`endif
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: scoreboard bench for inst_loader; write monitor checks every wr_en against queued expectations
module tb_inst_loader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, wr_en, busy, done, error;
  logic [7:0] wr_addr;
  logic [15:0] wr_data;
  int errors = 0, checks = 0;
  logic [23:0] sb[$];
  logic [23:0] mon_exp;

  always #5 clk = ~clk;

  inst_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: required event did not happen", name);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && wr_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", wr_addr, wr_data);
      end else begin
        mon_exp = sb.pop_front();
        chk("write", {8'h00, wr_addr, wr_data}, {8'h00, mon_exp});
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      in_data = 8'hEE;
      tick();
    end
    in_valid = 1'b1;
    in_data = b;
    for (int t = 0; t < 40; t++) begin
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    fail("in_ready_timeout");
  endtask

  task automatic pulse_start(input logic v, input logic [7:0] b);
    start = 1'b1;
    in_valid = v;
    in_data = b;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", error, 0);
  endtask

  task automatic wait_done(input logic exp_err);
    for (int t = 0; t < 20 && !done; t++) tick();
    chk("done", done, 1);
    chk("busy_low", busy, 0);
    chk("error", error, exp_err);
    chk("in_ready_idle", in_ready, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic load(input int nw, input bit jitter, input int restart_at);
    logic [7:0] cs, hi, lo;
    cs = nw[7:0];
    pulse_start(1'b0, 8'h00);
    send(nw[7:0], 0);
    for (int i = 0; i < nw; i++) begin
      hi = 8'(i) ^ 8'h5A;
      lo = ~8'(i);
      if (i == restart_at) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_ignored_busy", busy, 1);
      end
      sb.push_back({8'(i), hi, lo});
      send(hi, jitter ? int'($urandom_range(0, 3)) : 0);
      send(lo, jitter ? int'($urandom_range(0, 3)) : 0);
      cs ^= hi ^ lo;
    end
`ifdef LOADER_CHECKSUM_EN
    send(cs, 0);
`endif
    wait_done(1'b0);
  endtask

  initial begin
    logic [7:0] bq[$];
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_addr_data", {wr_addr, wr_data}, 0);
    repeat (3) tick();
    chk("rst_clocked_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    pulse_start(1'b1, 8'h02);
    chk("count_ready", in_ready, 1);
    sb.push_back({8'h00, 16'h1234});
    sb.push_back({8'h01, 16'hABCD});
    bq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    foreach (bq[i]) send(bq[i], 0);
`ifdef LOADER_CHECKSUM_EN
    send(8'h42, 0);
`endif
    wait_done(1'b0);
    chk("addr_after_2", wr_addr, 8'h02);

    in_valid = 1'b1;
    in_data = 8'hFF;
    repeat (3) begin
      tick();
      chk("idle_not_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    load(256, 1'b0, -1);
    chk("addr_wrapped", wr_addr, 8'h00);

`ifdef LOADER_CHECKSUM_EN
    pulse_start(1'b0, 8'h00);
    sb.push_back({8'h00, 16'h1234});
    bq = '{8'h01, 8'h12, 8'h34, 8'h27};
    foreach (bq[i]) send(bq[i], 0);
    wait_done(1'b0);
    pulse_start(1'b0, 8'h00);
    sb.push_back({8'h00, 16'h1234});
    bq = '{8'h01, 8'h12, 8'h34, 8'h00};
    foreach (bq[i]) send(bq[i], 0);
    wait_done(1'b1);
`endif

    load(3, 1'b1, -1);
    load(4, 1'b0, 2);

    pulse_start(1'b0, 8'h00);
    send(8'h02, 0);
    send(8'h12, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_done", done, 0);
    chk("abort_addr_data", {wr_addr, wr_data}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    load(2, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    fail("global_timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
